// File: rtl/gmii_tx_arbiter.sv
`timescale 1ns/1ps
// gmii_tx_arbiter
//   Frame-level arbiter that shares one GMII transmit path between the ARP
//   responder and the UDP transmitter. A sender raises its req. The arbiter
//   grants the link to that sender alone and forwards its tx_en/txd with one
//   register stage. After each frame it enforces an idle gap before the next
//   grant. The senders alternate on contention. A sender that never starts is
//   timed out, and a frame that runs too long is truncated.
//
// Ports
//   gmii_tx_clk   sole clock
//   rstn          asynchronous active-low reset
//   arp_req       ARP sender requests the link (level)
//   arp_tx_en     ARP GMII enable
//   arp_txd[7:0]  ARP GMII data
//   udp_req       UDP sender requests the link (level)
//   udp_tx_en     UDP GMII enable
//   udp_txd[7:0]  UDP GMII data
//   arp_grant     ARP owns the link
//   udp_grant     UDP owns the link
//   gmii_tx_en    registered enable to the PHY adapter
//   gmii_txd[7:0] registered data to the PHY adapter
//   busy          arbiter is not idle
//   timeout_err   one-cycle pulse when a granted sender fails to start
//   oversize_err  one-cycle pulse when a frame is truncated
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | no owner; arbitrate pending requests on each edge
// S_GRANT | winner granted; waiting for its tx_en (start timer running)
// S_SEND  | forwarding the winner's frame (frame length counter running)
// S_ABORT | frame truncated; output muted until the winner drops tx_en
// S_GAP   | inter-frame gap; no grants, output idle

module gmii_tx_arbiter #(
  parameter int IFG_CYCLES       = 12,
  parameter int START_TIMEOUT    = 64,
  parameter int MAX_FRAME_CYCLES = 1534
) (
  input  logic       gmii_tx_clk,
  input  logic       rstn,
  input  logic       arp_req,
  input  logic       arp_tx_en,
  input  logic [7:0] arp_txd,
  input  logic       udp_req,
  input  logic       udp_tx_en,
  input  logic [7:0] udp_txd,
  output logic       arp_grant,
  output logic       udp_grant,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       timeout_err,
  output logic       oversize_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SEND  = 3'd2,
    S_ABORT = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // Terminal-count values, sized to the 16-bit counters.
  localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] FRAME_MAX  = 16'(MAX_FRAME_CYCLES);
  localparam logic [15:0] GAP_LAST   = 16'(IFG_CYCLES - 1);

  state_t      state;
  logic        win_arp;    // current owner: 1 = ARP, 0 = UDP
  logic        last_arp;   // winner of the most recent arbitration
  logic [15:0] start_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] gap_cnt;

  logic       win_req;
  logic       win_tx_en;
  logic [7:0] win_txd;
  logic       pick_arp;

  // Only the owner's lanes are ever looked at. The other sender is invisible.
  assign win_req   = win_arp ? arp_req   : udp_req;
  assign win_tx_en = win_arp ? arp_tx_en : udp_tx_en;
  assign win_txd   = win_arp ? arp_txd   : udp_txd;

  // A lone requester wins. On a tie the sender that did not win last time
  // gets the link.
  assign pick_arp = arp_req && (!udp_req || !last_arp);

  // The counters stick at full scale instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge gmii_tx_clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      win_arp      <= 1'b0;
      last_arp     <= 1'b0;
      start_cnt    <= 16'd0;
      frame_cnt    <= 16'd0;
      gap_cnt      <= 16'd0;
      arp_grant    <= 1'b0;
      udp_grant    <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= 8'h00;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      // Error flags are pulses, and the output lane is idle unless a state
      // below forwards data.
      timeout_err  <= 1'b0;
      oversize_err <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= 8'h00;

      case (state)
        S_IDLE: begin
          if (arp_req || udp_req) begin
            state     <= S_GRANT;
            busy      <= 1'b1;
            win_arp   <= pick_arp;
            last_arp  <= pick_arp;
            arp_grant <= pick_arp;
            udp_grant <= !pick_arp;
            start_cnt <= 16'd0;
          end
        end

        S_GRANT: begin
          // Forward from the first sampled byte so that the frame start has
          // the same one-cycle latency as the rest of the frame.
          gmii_tx_en <= win_tx_en;
          gmii_txd   <= win_txd;
          if (win_tx_en) begin
            state     <= S_SEND;
            frame_cnt <= 16'd1;
          end else if (!win_req) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            arp_grant <= 1'b0;
            udp_grant <= 1'b0;
          end else if (start_cnt >= START_LAST) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            arp_grant   <= 1'b0;
            udp_grant   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            start_cnt <= sat_inc(start_cnt);
          end
        end

        S_SEND: begin
          if (!win_tx_en) begin
            gmii_txd  <= win_txd;
            state     <= S_GAP;
            gap_cnt   <= 16'd0;
            arp_grant <= 1'b0;
            udp_grant <= 1'b0;
          end else if (frame_cnt >= FRAME_MAX) begin
            // frame_cnt counts cycles already driven high, so the output has
            // been high for exactly FRAME_MAX cycles when this branch is taken.
            state        <= S_ABORT;
            arp_grant    <= 1'b0;
            udp_grant    <= 1'b0;
            oversize_err <= 1'b1;
          end else begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= win_txd;
            frame_cnt  <= sat_inc(frame_cnt);
          end
        end

        S_ABORT: begin
          // Hold the link muted until the runaway sender lets go, so that its
          // tail is never taken for the start of a new frame.
          if (!win_tx_en) begin
            state   <= S_GAP;
            gap_cnt <= 16'd0;
          end
        end

        S_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= sat_inc(gap_cnt);
          end
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          arp_grant <= 1'b0;
          udp_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gmii_tx_arbiter.md
# gmii_tx_arbiter

Frame-level arbiter sharing the single GMII transmit path between the ARP responder and the UDP transmitter, in the `gmii_tx_clk` domain. It sits between those two senders and `gmii_to_rgmii`. Each sender requests the link, receives an exclusive grant, and has its frame forwarded with one cycle of latency. The arbiter enforces a minimum inter-frame gap, alternates between senders on contention, and recovers from a sender that stalls or overruns.

## Interface
Parameters:
- `IFG_CYCLES`, 12: idle cycles inserted after every frame end.
- `START_TIMEOUT`, 64: cycles a granted sender has to raise tx_en before the grant is revoked.
- `MAX_FRAME_CYCLES`, 1534: maximum tx_en-high cycles per frame (preamble + 1518 + margin).

Ports (one clock; reset is asynchronous and active-low):
- `gmii_tx_clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous active-low reset.
- `arp_req`  in  1  ARP sender requests link (level).
- `arp_tx_en`  in  1  ARP GMII enable.
- `arp_txd`  in  8  ARP GMII data.
- `udp_req`  in  1  UDP sender requests link (level).
- `udp_tx_en`  in  1  UDP GMII enable.
- `udp_txd`  in  8  UDP GMII data.
- `arp_grant`  out  1  ARP owns link.
- `udp_grant`  out  1  UDP owns link.
- `gmii_tx_en`  out  1  registered enable to PHY adapter.
- `gmii_txd`  out  8  registered data to PHY adapter.
- `busy`  out  1  state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse on start timeout.
- `oversize_err`  out  1  one-cycle pulse on frame truncation.

## Operation
- States: IDLE, GRANT, SEND, ABORT, GAP.
- IDLE: if any req is high, go to GRANT and assert the winner's grant.
  - Only one requester: it wins.
  - Both requesters: UDP wins if `last_arp`=1, else ARP wins.
  - `last_arp` is updated to the winner at grant time. Its reset value is 0, so ARP wins the first tie.
- GRANT: the start counter increments each cycle.
  - Winner's tx_en=1 → SEND, frame counter=1.
  - Winner's req=0 with tx_en=0 → IDLE, no error.
  - Start counter reaches START_TIMEOUT-1 → IDLE, grant drops, `timeout_err` pulses.
- SEND: forward the winner's tx_en/txd; the frame counter increments.
  - Winner's tx_en=0 → GAP.
  - Frame counter reaches MAX_FRAME_CYCLES with tx_en still 1 → ABORT, `oversize_err` pulses.
- ABORT: output forced to 0 and grant dropped. When the winner's tx_en=0 → GAP.
- GAP: gap counter runs 0..IFG_CYCLES-1, then IDLE. Grants are 0 throughout.
- The non-granted sender's tx_en/txd are ignored in every state. Any enable it raises is never forwarded.
- Counters are 16 bits and saturate; they never wrap.

## Timing
- Reset value of every output is 0, asynchronously, including mid-frame: `gmii_tx_en` drops immediately. State returns to IDLE, counters to 0, `last_arp` to 0.
- Grant latency: req sampled high in IDLE at edge n → grant high after edge n.
- Data latency: `gmii_tx_en`/`gmii_txd` after edge k equal the winner's tx_en/txd sampled at edge k. This holds in GRANT and SEND, for both the first and last byte. In all other states the outputs are 0/0x00.
- Grant stays high through GRANT and SEND. It falls on the same edge that samples the winner's tx_en=0, or on entry to ABORT.
- Idle on `gmii_tx_en` between two frames is ≥ IFG_CYCLES+2 cycles: GAP, then the IDLE sample, then the sender's one-cycle response to grant.
- Truncation: `gmii_tx_en` is high for exactly MAX_FRAME_CYCLES cycles, then 0.
- A req asserted during GAP/ABORT is held pending and arbitrated in IDLE. A req dropped during SEND has no effect; only tx_en ends the frame.
- Error pulses are exactly one cycle and coincide with the state change.

## Test plan
- ARP only: arp_req=1 at t0; sender drives 60 bytes 0x01..0x3C one cycle after grant.
  - `arp_grant` is high after t0's edge.
  - `gmii_txd` replays 0x01..0x3C one cycle delayed, with tx_en high 60 cycles.
  - GAP lasts 12 cycles, then `busy`=0.
- Contention: both req held high, each sender sends 64-byte frames.
  - Grants alternate ARP, UDP, ARP, UDP.
  - Each gap on `gmii_tx_en` is ≥14 cycles.
  - udp_tx_en toggled while ARP is granted never appears at the output.
- Start timeout: udp_req=1 and tx_en never raised.
  - `udp_grant` falls after 64 cycles with a one-cycle `timeout_err`.
  - arp_req pending is granted next.
- Oversize: ARP holds tx_en for 2000 cycles.
  - Output tx_en is high exactly 1534 cycles.
  - `oversize_err` pulses once.
  - Stays in ABORT until arp_tx_en=0, then a 12-cycle GAP.
- Cancel: udp_req rises then falls after 3 cycles with tx_en=0 → back to IDLE, no error pulse.
- Reset mid-frame: rstn low at byte 30 of a UDP frame → all outputs 0 immediately. After release, a tie is won by ARP.
